memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter and access sequencer placed in front of `memory_bus`. It lets the CPU core (port 0) and a DMA/loader engine (port 1) share the single 16-bit address / 8-bit data bus. Port 0 has priority, with a bounded-starvation guarantee for port 1. Each access is sequenced as a fixed multi-cycle transaction ending in a one-cycle `ready` pulse, which lets requesters stall on slow banks.

## Interface
Parameters:
- `READ_WAIT`, default 1: extra cycles the bus is held after the access cycle of a read, before data is captured (0–7).
- `MAX_HOLD`, default 8: consecutive port-0 grants allowed while port 1 is waiting (1–15).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request; held high, with address/data stable, until `ready`
- `m0_address`, `m1_address`  in  16  byte address
- `m0_write`, `m1_write`  in  1  1 = write, 0 = read
- `m0_wdata`, `m1_wdata`  in  8  write data
- `m0_rdata`, `m1_rdata`  out  8  read data, registered, valid from `ready` until the next read completes for that port
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse
- `bus_address`  out  16  to `memory_bus` `address`
- `bus_data_in`  out  8  to `memory_bus` `data_in`
- `bus_data_out`  in  8  from `memory_bus` `data_out`
- `bus_enable`, `bus_write_enable`  out  1  to `memory_bus`
- `owner`  out  1  port currently granted; meaningful while `busy`
- `busy`  out  1  high outside IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: drive the bus.
  - WAIT: read hold for `READ_WAIT` cycles.
  - DONE: capture data and pulse `ready`.
- All outputs are registered.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant port 0 unless `starve_cnt == MAX_HOLD`, in which case grant port 1.
- `starve_cnt` (4 bits):
  - Increments on each port-0 grant made while `m1_req` = 1.
  - Clears on any port-1 grant, and in any IDLE cycle where `m1_req` = 0.
  - Saturates at `MAX_HOLD`.
- On grant: latch the owner's address, write flag and wdata into internal registers, then enter ACCESS. The bus is driven only from these latched copies.
- ACCESS (1 cycle):
  - `bus_enable` = 1; `bus_address`/`bus_data_in` carry the latched values.
  - `bus_write_enable` = 1 only on writes, and for exactly this one cycle.
  - Next state: write → DONE; read with `READ_WAIT` = 0 → DONE; otherwise WAIT.
- WAIT: `bus_enable` = 1, `bus_write_enable` = 0, address held. A 3-bit counter moves to DONE after `READ_WAIT` cycles.
- DONE (1 cycle):
  - The owner's `ready` = 1.
  - For reads, the owner's `rdata` was loaded from `bus_data_out` on the edge entering DONE.
  - `bus_enable` = 0. Next state: IDLE.
- A requester dropping `req` mid-transaction does not abort it; `ready` still pulses. The non-owner's `ready` and `rdata` are never touched.
- In IDLE/DONE, `bus_address`, `bus_data_in` and the enables are all 0.

## Timing
- Reset values: state IDLE; all outputs 0; `starve_cnt` 0; latched registers 0.
- Asserting `reset` mid-transaction forces IDLE immediately and drops `bus_write_enable` asynchronously. No partial transaction resumes after reset.
- Latency, measured from the IDLE edge that samples `req` (cycle 0) to `ready`:
  - Write: `ready` in cycle 2 (ACCESS in 1, DONE in 2).
  - Read: `ready` in cycle 2 + `READ_WAIT`.
- Minimum issue interval per transaction: write 3 cycles, read 3 + `READ_WAIT` (includes the IDLE arbitration cycle).
- A requester that re-asserts, or keeps holding, `req` in the cycle after `ready` is treated as a new request. Therefore requesters must drop `req` in the `ready` cycle, or accept a repeated access.
- Simultaneous requests in one IDLE cycle are resolved by the priority/`starve_cnt` rule only. There is no tie-breaking on address.

## Structure
- Shared package `memory_arbiter_pkg`:
  - State encoding constants `STATE_IDLE`, `STATE_ACCESS`, `STATE_WAIT`, `STATE_DONE` (2 bits).
  - Port index constants `PORT_CPU` = 0, `PORT_DMA` = 1.
- Single module. The grant decision (requests + `starve_cnt` → grant, valid) is a natural sub-module, `memory_arbiter_pick`: purely combinational, tested standalone.

## Test plan
- Reset then single read: port 0 reads 0x0010 holding 0x5A, `READ_WAIT` = 1 → `bus_enable` high for 2 cycles, `m0_ready` pulses in cycle 3, `m0_rdata` = 0x5A.
- Single write: port 1 writes 0xA5 to 0xC004 → `bus_write_enable` high exactly 1 cycle with `bus_address` = 0xC004, `bus_data_in` = 0xA5; `m1_ready` pulses in cycle 2; a read-back returns 0xA5.
- Starvation bound: both ports hold requests continuously, `MAX_HOLD` = 8 → port 0 gets 8 grants, port 1 gets the 9th, and the pattern repeats.
- Simultaneous start: `m0_req` and `m1_req` both rise in the same cycle with `starve_cnt` = 0 → port 0 is granted first; `m1_ready` only follows port 0's DONE.
- Reset mid-write: assert `reset` during ACCESS → `bus_write_enable` falls before the next edge, no `ready` pulses, state is IDLE after release.
- Request withdrawn: `m1_req` drops during WAIT → transaction completes, `m1_ready` still pulses once, `m0_*` outputs are unchanged.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   - 2-bit state encoding constants and the matching FSM enum
//   - port index constants (CPU = port 0, DMA = port 1)
//   - latched access record and a saturating increment helper
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_WAIT   = 2'd2;
    localparam logic [1:0] STATE_DONE   = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = STATE_IDLE,
        StAccess = STATE_ACCESS,
        StWait   = STATE_WAIT,
        StDone   = STATE_DONE
    } state_e;

    // Copy of the granted request; the bus is driven only from this record.
    typedef struct packed {
        logic [15:0] address;
        logic        write;
        logic [7:0]  wdata;
    } access_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
// Groups the requester handshakes, the memory_bus side and the status outputs
// of memory_arbiter.
//   slave  : view of the arbiter (requests and bus read data in; ready, rdata,
//            bus drive and status out)
//   master : view of the environment (requesters plus the memory_bus model)
// -----------------------------------------------------------------------------
interface memory_arbiter_if;

    // Port 0 (CPU)
    logic        m0_req;
    logic [15:0] m0_address;
    logic        m0_write;
    logic [7:0]  m0_wdata;
    logic [7:0]  m0_rdata;
    logic        m0_ready;

    // Port 1 (DMA / loader)
    logic        m1_req;
    logic [15:0] m1_address;
    logic        m1_write;
    logic [7:0]  m1_wdata;
    logic [7:0]  m1_rdata;
    logic        m1_ready;

    // memory_bus side
    logic [15:0] bus_address;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_enable;
    logic        bus_write_enable;

    // Status
    logic        owner;
    logic        busy;

    modport slave (
        input  m0_req, m0_address, m0_write, m0_wdata,
        input  m1_req, m1_address, m1_write, m1_wdata,
        input  bus_data_out,
        output m0_rdata, m0_ready, m1_rdata, m1_ready,
        output bus_address, bus_data_in, bus_enable, bus_write_enable,
        output owner, busy
    );

    modport master (
        output m0_req, m0_address, m0_write, m0_wdata,
        output m1_req, m1_address, m1_write, m1_wdata,
        output bus_data_out,
        input  m0_rdata, m0_ready, m1_rdata, m1_ready,
        input  bus_address, bus_data_in, bus_enable, bus_write_enable,
        input  owner, busy
    );

endinterface

// File: rtl/memory_arbiter_pick.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pick
// Purely combinational grant decision.
//   req0_i       : port 0 (CPU) request
//   req1_i       : port 1 (DMA) request
//   starve_cnt_i : consecutive port-0 grants made while port 1 was waiting
//   grant_o      : granted port index (PORT_CPU when nothing is requested)
//   valid_o      : at least one request is pending
// Port 0 wins a tie unless port 1 has already been passed over MAX_HOLD times.
// -----------------------------------------------------------------------------
module memory_arbiter_pick
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [3:0] starve_cnt_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        grant_o = PORT_CPU;
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            grant_o = (starve_cnt_i == 4'(MAX_HOLD)) ? PORT_DMA : PORT_CPU;
        end else if (req1_i) begin
            grant_o = PORT_DMA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Two-port arbiter and access sequencer in front of memory_bus.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   arb_io : memory_arbiter_if.slave
//            m0_* / m1_* request handshakes (req, address, write, wdata in;
//            rdata, ready out), bus_* drive towards memory_bus, owner, busy.
// Every transaction runs IDLE -> ACCESS -> [WAIT x READ_WAIT] -> DONE with a
// one-cycle ready pulse in DONE. All outputs are registers loaded from the
// next-state values, so an output reflects the state it is registered with.
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned READ_WAIT = 1,
    parameter int unsigned MAX_HOLD  = 8
) (
    input logic             clk,
    input logic             reset,
    memory_arbiter_if.slave arb_io
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    access_t     acc_q, acc_d;
    logic [3:0]  starve_q, starve_d;
    logic [2:0]  wait_q, wait_d;

    logic        bus_en_q, bus_en_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_din_q, bus_din_d;
    logic        ready0_q, ready0_d;
    logic        ready1_q, ready1_d;
    logic [7:0]  rdata0_q, rdata0_d;
    logic [7:0]  rdata1_q, rdata1_d;
    logic        busy_q, busy_d;

    logic        grant;
    logic        grant_valid;
    logic        capture;

    memory_arbiter_pick #(
        .MAX_HOLD(MAX_HOLD)
    ) u_pick (
        .req0_i      (arb_io.m0_req),
        .req1_i      (arb_io.m1_req),
        .starve_cnt_i(starve_q),
        .grant_o     (grant),
        .valid_o     (grant_valid)
    );

    // Next-state logic: sequencing, latching and starvation tracking.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        acc_d    = acc_q;
        starve_d = starve_q;
        wait_d   = wait_q;

        unique case (state_q)
            StIdle: begin
                if (!arb_io.m1_req) begin
                    starve_d = 4'd0;
                end
                if (grant_valid) begin
                    owner_d = grant;
                    state_d = StAccess;
                    if (grant == PORT_DMA) begin
                        acc_d.address = arb_io.m1_address;
                        acc_d.write   = arb_io.m1_write;
                        acc_d.wdata   = arb_io.m1_wdata;
                        starve_d      = 4'd0;
                    end else begin
                        acc_d.address = arb_io.m0_address;
                        acc_d.write   = arb_io.m0_write;
                        acc_d.wdata   = arb_io.m0_wdata;
                        if (arb_io.m1_req) begin
                            starve_d = sat_inc(starve_q, 4'(MAX_HOLD));
                        end
                    end
                end
            end
            StAccess: begin
                if (acc_q.write || (READ_WAIT == 0)) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                    // Counts down the remaining hold cycles, WAIT exits at zero.
                    wait_d  = 3'(READ_WAIT - 1);
                end
            end
            StWait: begin
                if (wait_q == 3'd0) begin
                    state_d = StDone;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next-values, derived from the state being entered.
    always_comb begin
        bus_en_d   = (state_d == StAccess) || (state_d == StWait);
        bus_we_d   = (state_d == StAccess) && acc_d.write;
        bus_addr_d = bus_en_d ? acc_d.address : 16'h0000;
        bus_din_d  = bus_en_d ? acc_d.wdata : 8'h00;
        busy_d     = (state_d != StIdle);

        ready0_d   = (state_d == StDone) && (owner_d == PORT_CPU);
        ready1_d   = (state_d == StDone) && (owner_d == PORT_DMA);

        // DONE is only ever entered from ACCESS or WAIT, so this fires once.
        capture    = (state_d == StDone) && (state_q != StDone) && !acc_d.write;
        rdata0_d   = (capture && (owner_d == PORT_CPU)) ? arb_io.bus_data_out : rdata0_q;
        rdata1_d   = (capture && (owner_d == PORT_DMA)) ? arb_io.bus_data_out : rdata1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            owner_q    <= PORT_CPU;
            acc_q      <= '0;
            starve_q   <= 4'd0;
            wait_q     <= 3'd0;
            bus_en_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 16'h0000;
            bus_din_q  <= 8'h00;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            rdata0_q   <= 8'h00;
            rdata1_q   <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            acc_q      <= acc_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            bus_en_q   <= bus_en_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_din_q  <= bus_din_d;
            ready0_q   <= ready0_d;
            ready1_q   <= ready1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign arb_io.m0_ready         = ready0_q;
    assign arb_io.m1_ready         = ready1_q;
    assign arb_io.m0_rdata         = rdata0_q;
    assign arb_io.m1_rdata         = rdata1_q;
    assign arb_io.bus_address      = bus_addr_q;
    assign arb_io.bus_data_in      = bus_din_q;
    assign arb_io.bus_enable       = bus_en_q;
    assign arb_io.bus_write_enable = bus_we_q;
    assign arb_io.owner            = owner_q;
    assign arb_io.busy             = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Self-checking bench for memory_arbiter (READ_WAIT = 1, MAX_HOLD = 8) and its
// memory_arbiter_pick sub-block. A byte-array memory stands in for memory_bus.
// A transaction-level model predicts grants, ready timing, bus activity and
// read data from the arbitration rules and the fixed transaction lengths.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int unsigned RW = 1;
    localparam int unsigned MH = 8;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_arbiter_if arb ();

    memory_arbiter #(
        .READ_WAIT(RW),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb_io(arb)
    );

    logic       pk_r0;
    logic       pk_r1;
    logic [3:0] pk_cnt;
    logic       pk_g;
    logic       pk_v;

    memory_arbiter_pick #(
        .MAX_HOLD(MH)
    ) u_pick (
        .req0_i      (pk_r0),
        .req1_i      (pk_r1),
        .starve_cnt_i(pk_cnt),
        .grant_o     (pk_g),
        .valid_o     (pk_v)
    );

    logic [7:0] mem [65536];
    logic [7:0] ref_mem [65536];

    assign arb.bus_data_out = mem[arb.bus_address];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction-level model state
    bit          m_act;
    bit          m_own;
    bit          m_wr;
    logic [15:0] m_addr;
    logic [7:0]  m_wd;
    int          g_edge;
    int          rdy_edge;
    int          free_at;
    int          m_starve;
    logic [7:0]  m_rd [2];

    logic [15:0] last_wa;
    logic [7:0]  last_wd;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] cnt;
        logic       v;
        logic       g;
    } pick_vec_t;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'd7 + 16'd3;
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act    = 1'b0;
        m_starve = 0;
        m_rd[0]  = 8'h00;
        m_rd[1]  = 8'h00;
        free_at  = 0;
    endtask

    // Called at each rising edge with the inputs as sampled by that edge.
    task automatic model_edge();
        bit r0;
        bit r1;
        bit p;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_act && m_wr && (cyc == g_edge + 1)) ref_mem[m_addr] = m_wd;
        if (m_act && !m_wr && (cyc == rdy_edge)) m_rd[m_own] = ref_mem[m_addr];
        if (m_act && (cyc > rdy_edge)) m_act = 1'b0;
        if (!m_act && (cyc >= free_at)) begin
            r0 = arb.m0_req;
            r1 = arb.m1_req;
            if (r0 || r1) begin
                p = (r0 && r1) ? (m_starve == int'(MH)) : r1;
                if (p || !r1) m_starve = 0;
                else if (m_starve < int'(MH)) m_starve = m_starve + 1;
                m_act  = 1'b1;
                m_own  = p;
                m_wr   = p ? arb.m1_write : arb.m0_write;
                m_addr = p ? arb.m1_address : arb.m0_address;
                m_wd   = p ? arb.m1_wdata : arb.m0_wdata;
                g_edge = cyc;
                rdy_edge = cyc + 1 + (m_wr ? 0 : int'(RW));
                free_at  = rdy_edge + 2;
            end else begin
                m_starve = 0;
            end
        end
    endtask

    task automatic compare_all();
        bit e_en;
        bit e_we;
        bit e_rdy;
        e_en  = m_act && (cyc < rdy_edge);
        e_we  = m_act && m_wr && (cyc == g_edge);
        e_rdy = m_act && (cyc == rdy_edge);
        chk("busy", 32'(arb.busy), 32'(m_act));
        if (m_act) chk("owner", 32'(arb.owner), 32'(m_own));
        chk("m0_ready", 32'(arb.m0_ready), 32'(e_rdy && !m_own));
        chk("m1_ready", 32'(arb.m1_ready), 32'(e_rdy && m_own));
        chk("m0_rdata", 32'(arb.m0_rdata), 32'(m_rd[0]));
        chk("m1_rdata", 32'(arb.m1_rdata), 32'(m_rd[1]));
        chk("bus_enable", 32'(arb.bus_enable), 32'(e_en));
        chk("bus_write_enable", 32'(arb.bus_write_enable), 32'(e_we));
        chk("bus_address", 32'(arb.bus_address), e_en ? 32'(m_addr) : 32'd0);
        if (e_we) chk("bus_data_in_wr", 32'(arb.bus_data_in), 32'(m_wd));
        if (!e_en) chk("bus_data_in_idle", 32'(arb.bus_data_in), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (arb.bus_write_enable) mem[arb.bus_address] = arb.bus_data_in;
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input int p, input logic rq, input logic [15:0] a, input logic w,
                         input logic [7:0] d);
        if (p == 0) begin
            arb.m0_req = rq; arb.m0_address = a; arb.m0_write = w; arb.m0_wdata = d;
        end else begin
            arb.m1_req = rq; arb.m1_address = a; arb.m1_write = w; arb.m1_wdata = d;
        end
    endtask

    task automatic set_req(input int p, input logic rq);
        if (p == 0) arb.m0_req = rq;
        else arb.m1_req = rq;
    endtask

    function automatic logic get_req(input int p);
        return (p == 0) ? arb.m0_req : arb.m1_req;
    endfunction

    function automatic logic get_ready(input int p);
        return (p == 0) ? arb.m0_ready : arb.m1_ready;
    endfunction

    // One request on port p; req is dropped in the ready cycle.
    task automatic txn(input int p, input logic [15:0] a, input logic w, input logic [7:0] d,
                       output int rc, output int en_cnt, output int we_cnt);
        drive(p, 1'b1, a, w, d);
        rc = -1;
        en_cnt = 0;
        we_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (arb.bus_enable) en_cnt++;
            if (arb.bus_write_enable) begin
                we_cnt++;
                last_wa = arb.bus_address;
                last_wd = arb.bus_data_in;
            end
            if (get_ready(p) && (rc < 0)) begin
                rc = i;
                set_req(p, 1'b0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pick_vec_t vec [10];
        int rc;
        int rc1;
        int en_cnt;
        int we_cnt;
        int ng;
        int r0_cnt;
        int r1_cnt;
        bit prev_busy;
        logic owners [18];
        int gap [2];

        reset = 1'b0;
        drive(0, 1'b0, 16'h0000, 1'b0, 8'h00);
        drive(1, 1'b0, 16'h0000, 1'b0, 8'h00);
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = init_val(16'(i));
            ref_mem[i] = init_val(16'(i));
        end
        mem[16'h0010]     = 8'h5A;
        ref_mem[16'h0010] = 8'h5A;
        model_reset();

        // Standalone grant decision: {r0, r1, cnt, valid, grant}
        vec[0] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
        vec[2] = '{1'b0, 1'b1, 4'd0, 1'b1, 1'b1};
        vec[3] = '{1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
        vec[4] = '{1'b1, 1'b1, 4'd7, 1'b1, 1'b0};
        vec[5] = '{1'b1, 1'b1, 4'd8, 1'b1, 1'b1};
        vec[6] = '{1'b0, 1'b1, 4'd8, 1'b1, 1'b1};
        vec[7] = '{1'b1, 1'b0, 4'd8, 1'b1, 1'b0};
        vec[8] = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b0};
        vec[9] = '{1'b0, 1'b0, 4'd8, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            pk_r0  = vec[i].r0;
            pk_r1  = vec[i].r1;
            pk_cnt = vec[i].cnt;
            #1;
            chk($sformatf("pick_valid[%0d]", i), 32'(pk_v), 32'(vec[i].v));
            chk($sformatf("pick_grant[%0d]", i), 32'(pk_g), 32'(vec[i].g));
        end

        // Reset state
        repeat (3) step();
        chk("rst_busy", 32'(arb.busy), 32'd0);
        chk("rst_owner", 32'(arb.owner), 32'd0);
        chk("rst_bus_enable", 32'(arb.bus_enable), 32'd0);
        chk("rst_m0_rdata", 32'(arb.m0_rdata), 32'd0);
        reset = 1'b1;
        step();
        step();

        // Single read by port 0 of 0x0010
        txn(0, 16'h0010, 1'b0, 8'h00, rc, en_cnt, we_cnt);
        chk("rd_ready_cycle", 32'(rc), 32'd3);
        chk("rd_enable_cycles", 32'(en_cnt), 32'd2);
        chk("rd_data", 32'(arb.m0_rdata), 32'h5A);

        // Single write by port 1, then read back
        txn(1, 16'hC004, 1'b1, 8'hA5, rc, en_cnt, we_cnt);
        chk("wr_ready_cycle", 32'(rc), 32'd2);
        chk("wr_we_cycles", 32'(we_cnt), 32'd1);
        chk("wr_we_address", 32'(last_wa), 32'hC004);
        chk("wr_we_data", 32'(last_wd), 32'hA5);
        txn(1, 16'hC004, 1'b0, 8'h00, rc, en_cnt, we_cnt);
        chk("wr_readback", 32'(arb.m1_rdata), 32'hA5);

        // Simultaneous start: port 0 first, port 1 after port 0's DONE
        drive(0, 1'b1, 16'h0011, 1'b0, 8'h00);
        drive(1, 1'b1, 16'h0012, 1'b0, 8'h00);
        rc = -1;
        rc1 = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (arb.m0_ready && (rc < 0)) begin rc = i; arb.m0_req = 1'b0; end
            if (arb.m1_ready && (rc1 < 0)) begin rc1 = i; arb.m1_req = 1'b0; end
        end
        chk("sim_m0_ready_cycle", 32'(rc), 32'd3);
        chk("sim_m1_ready_cycle", 32'(rc1), 32'd7);

        // Starvation bound: both hold writes continuously
        drive(0, 1'b1, 16'h0100, 1'b1, 8'h11);
        drive(1, 1'b1, 16'h0200, 1'b1, 8'h22);
        ng = 0;
        prev_busy = arb.busy;
        for (int i = 0; i < 200 && ng < 18; i++) begin
            step();
            if (arb.busy && !prev_busy) begin
                owners[ng] = arb.owner;
                ng++;
            end
            prev_busy = arb.busy;
        end
        chk("starve_grant_count", 32'(ng), 32'd18);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("starve_owner[%0d]", i), 32'(owners[i]), 32'((i % 9) == 8));
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (6) step();

        // Reset during the ACCESS cycle of a write
        drive(0, 1'b1, 16'h0020, 1'b1, 8'h77);
        step();
        chk("rstw_we_before", 32'(arb.bus_write_enable), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstw_we_async", 32'(arb.bus_write_enable), 32'd0);
        chk("rstw_busy_async", 32'(arb.busy), 32'd0);
        chk("rstw_enable_async", 32'(arb.bus_enable), 32'd0);
        set_req(0, 1'b0);
        r0_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (arb.m0_ready || arb.m1_ready) r0_cnt++;
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (arb.m0_ready || arb.m1_ready) r0_cnt++;
        end
        chk("rstw_no_ready", 32'(r0_cnt), 32'd0);
        chk("rstw_idle_after", 32'(arb.busy), 32'd0);
        txn(0, 16'h0020, 1'b0, 8'h00, rc, en_cnt, we_cnt);
        chk("rstw_mem_untouched", 32'(arb.m0_rdata), 32'hE3);

        // Port 1 withdraws its request during WAIT
        txn(0, 16'h0010, 1'b0, 8'h00, rc, en_cnt, we_cnt);
        drive(1, 1'b1, 16'hC004, 1'b0, 8'h00);
        step();
        step();
        set_req(1, 1'b0);
        r0_cnt = 0;
        r1_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (arb.m0_ready) r0_cnt++;
            if (arb.m1_ready) r1_cnt++;
        end
        chk("wd_m1_ready_count", 32'(r1_cnt), 32'd1);
        chk("wd_m0_ready_count", 32'(r0_cnt), 32'd0);
        chk("wd_m0_rdata_kept", 32'(arb.m0_rdata), 32'h5A);
        chk("wd_m1_rdata", 32'(arb.m1_rdata), 32'hA5);

        // Random traffic on both ports against the model
        gap[0] = 0;
        gap[1] = 0;
        for (int n = 0; n < 800; n++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (get_req(p)) begin
                    // Occasionally keep holding req to get a repeated access.
                    if (get_ready(p) && ($urandom_range(0, 4) != 0)) begin
                        set_req(p, 1'b0);
                        gap[p] = int'($urandom_range(0, 3));
                    end
                end else if (gap[p] == 0) begin
                    drive(p, 1'b1, 16'hC000 | 16'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 8'($urandom));
                end else begin
                    gap[p]--;
                end
            end
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
